// File: rtl/video_render_pl.sv
// video_render_pl: pipelined pixel renderer. Buffers fetched words in a small
// FIFO, steps a local pixel index on every c1 strobe, decodes ZX/16c/256c/text
// pixels, merges prioritised overlay layers and optionally packs hi-res pairs.
module video_render_pl #(
    parameter int DW      = 32,
    parameter int FDEPTH  = 4,
    parameter int NLAYERS = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 c1,
    input  logic                 line_start,
    input  logic [DW-1:0]        data_in,
    input  logic                 data_wr,
    output logic                 data_rdy,
    input  logic                 hvpix,
    input  logic                 nogfx,
    input  logic                 flash,
    input  logic                 hires,
    input  logic [3:0]           palsel,
    input  logic [1:0]           render_mode,
    input  logic [7:0]           border_in,
    input  logic [8*NLAYERS-1:0] ovl_data,
    output logic [7:0]           vplex_out,
    output logic                 underrun
);

    localparam int HW = DW / 2;          // gfx half width in bits
    localparam int NB = DW / 8;          // bytes per fetched word
    localparam int IW = $clog2(HW);      // pixel index width (max P = HW)
    localparam int BW = $clog2(NB);      // byte select width
    localparam int PW = $clog2(FDEPTH);  // FIFO pointer width

    typedef enum logic [1:0] {
        MODE_ZX   = 2'd0,
        MODE_16C  = 2'd1,
        MODE_256C = 2'd2,
        MODE_TEXT = 2'd3
    } mode_t;

    logic [DW-1:0]      mem [FDEPTH];
    logic [PW-1:0]      wptr, rptr;
    logic [PW:0]        count;
    logic               empty, full;
    logic               step, need, pop, push;

    mode_t              mode_l;
    logic [IW-1:0]      idx, last_idx;
    logic [NB-1:0][7:0] head;
    logic [BW-1:0]      zx_gb, zx_ab, c16_b, c256_b;
    logic [7:0]         gbyte, abyte, cbyte;
    logic               dot;
    logic [7:0]         bm_pix, video;
    logic               ovl_hit;
    logic [3:0]         temp;
    logic               phase;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FDEPTH));
    assign data_rdy = ~full;
    assign head     = mem[rptr];

    // line_start takes precedence over any pixel-rate activity in the same clk
    assign step = c1 & ~line_start;
    assign need = step & hvpix & ~nogfx;
    assign pop  = need & ~empty & (idx == last_idx);
    // a write into a full FIFO is still taken when the head word leaves this clk
    assign push = data_wr & (~full | pop);

    // last pixel index of a word for the latched mode
    always_comb begin
        last_idx = IW'(HW - 1);
        case (mode_l)
            MODE_16C:  last_idx = IW'(DW/4 - 1);
            MODE_256C: last_idx = IW'(DW/8 - 1);
            default:   last_idx = IW'(HW - 1);
        endcase
    end

    // bitmap pixel decode from the head word; border when nothing is buffered
    always_comb begin
        zx_gb  = BW'(idx >> 3);
        zx_ab  = zx_gb + BW'(NB/2);
        c16_b  = BW'(idx >> 1);
        c256_b = BW'(idx);
        gbyte  = head[zx_gb];
        abyte  = head[zx_ab];
        cbyte  = head[c16_b];
        dot    = gbyte[~idx[2:0]];
        bm_pix = border_in;
        if (!empty) begin
            case (mode_l)
                MODE_ZX:   bm_pix = {palsel, abyte[6],
                                     (dot ^ (flash & abyte[7])) ? abyte[2:0] : abyte[5:3]};
                MODE_TEXT: bm_pix = {palsel, dot ? abyte[3:0] : abyte[7:4]};
                MODE_16C:  bm_pix = {palsel, idx[0] ? cbyte[3:0] : cbyte[7:4]};
                default:   bm_pix = head[c256_b];
            endcase
        end
    end

    // overlay priority mux: lowest-numbered opaque layer wins, border outside active area
    always_comb begin
        video   = nogfx ? border_in : bm_pix;
        ovl_hit = 1'b0;
        for (int unsigned k = 0; k < NLAYERS; k++) begin
            if (!ovl_hit && ovl_data[8*k +: 4] != 4'h0) begin
                video   = ovl_data[8*k +: 8];
                ovl_hit = 1'b1;
            end
        end
        if (!hvpix) video = border_in;
    end

    // FIFO storage; after a flush a simultaneous write lands in entry 0
    always_ff @(posedge clk) begin
        if (line_start) begin
            if (data_wr) mem[0] <= data_in;
        end else if (push) begin
            mem[wptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (res) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (line_start) begin
            rptr  <= '0;
            wptr  <= data_wr ? PW'(1) : '0;
            count <= data_wr ? (PW+1)'(1) : '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // pixel index, mode latch, underrun flag and output register (pixel rate)
    always_ff @(posedge clk) begin
        if (res) begin
            idx       <= '0;
            mode_l    <= MODE_ZX;
            underrun  <= 1'b0;
            phase     <= 1'b0;
            temp      <= '0;
            vplex_out <= '0;
        end else if (line_start) begin
            idx      <= '0;
            mode_l   <= mode_t'(render_mode);
            underrun <= 1'b0;
            phase    <= 1'b0;
        end else if (step) begin
            phase <= ~phase;
            temp  <= video[3:0];
            if (!hires)     vplex_out <= video;
            else if (phase) vplex_out <= {temp, video[3:0]};
            if (need) begin
                if (empty)                 underrun <= 1'b1;
                else if (idx == last_idx)  idx      <= '0;
                else                       idx      <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_render_pl.sv
// Testbench for video_render_pl: directed spot checks followed by randomized
// stimulus, all compared against a queue-based behavioural model.
module tb_video_render_pl;

    localparam int DW      = 32;
    localparam int FDEPTH  = 4;
    localparam int NLAYERS = 2;

    logic                 clk = 1'b0;
    logic                 res, c1, line_start, data_wr, data_rdy;
    logic [DW-1:0]        data_in;
    logic                 hvpix, nogfx, flash, hires, underrun;
    logic [3:0]           palsel;
    logic [1:0]           render_mode;
    logic [7:0]           border_in, vplex_out;
    logic [8*NLAYERS-1:0] ovl_data;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    int            m_idx, m_mode;
    logic          m_und, m_phase;
    logic [3:0]    m_temp;
    logic [7:0]    m_vout;

    logic [7:0] c16_exp  [8] = '{8'hA2, 8'hA1, 8'hA4, 8'hA3, 8'hA6, 8'hA5, 8'hA8, 8'hA7};
    logic [7:0] c256_exp [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    int         rb_words [4] = '{1, 2, 3, 5};

    video_render_pl #(.DW(DW), .FDEPTH(FDEPTH), .NLAYERS(NLAYERS)) dut (
        .clk(clk), .res(res), .c1(c1), .line_start(line_start),
        .data_in(data_in), .data_wr(data_wr), .data_rdy(data_rdy),
        .hvpix(hvpix), .nogfx(nogfx), .flash(flash), .hires(hires),
        .palsel(palsel), .render_mode(render_mode), .border_in(border_in),
        .ovl_data(ovl_data), .vplex_out(vplex_out), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int ppw(input int m);
        return (m == 1) ? DW/4 : (m == 2) ? DW/8 : DW/2;
    endfunction

    function automatic logic [7:0] decode(input logic [31:0] w, input int i, input int m,
                                          input logic [3:0] pal, input logic fl);
        logic [7:0] g, a, by;
        logic       d;
        int         b;
        case (m)
            0, 3: begin
                b = i / 8;
                g = 8'(w >> (8*b));
                a = 8'(w >> (DW/2 + 8*b));
                d = g[7 - (i % 8)];
                if (m == 0) return {pal, a[6], (d ^ (fl & a[7])) ? a[2:0] : a[5:3]};
                return {pal, d ? a[3:0] : a[7:4]};
            end
            1: begin
                by = 8'(w >> (8*(i/2)));
                return {pal, (i % 2 == 0) ? by[7:4] : by[3:0]};
            end
            default: return 8'(w >> (8*i));
        endcase
    endfunction

    function automatic logic [31:0] mkw(input int k);
        return {8'(16*k + 3), 8'(16*k + 2), 8'(16*k + 1), 8'(16*k)};
    endfunction

    // one clk: advance the model on the current inputs, then compare after the edge
    task automatic tick();
        logic [7:0] video, bm;
        bit         popd, accept;
        if (res) begin
            mq.delete(); m_idx = 0; m_mode = 0; m_und = 0;
            m_vout = 8'h00; m_temp = 4'h0; m_phase = 0;
        end else if (line_start) begin
            mq.delete();
            if (data_wr) mq.push_back(data_in);
            m_idx = 0; m_mode = int'(render_mode); m_und = 0; m_phase = 0;
        end else begin
            popd = 0;
            if (c1) begin
                bm = border_in;
                if (hvpix && !nogfx) begin
                    if (mq.size() == 0) m_und = 1;
                    else begin
                        bm = decode(mq[0], m_idx, m_mode, palsel, flash);
                        if (m_idx == ppw(m_mode) - 1) begin popd = 1; m_idx = 0; end
                        else m_idx++;
                    end
                end
                video = nogfx ? border_in : bm;
                for (int k = NLAYERS - 1; k >= 0; k--)
                    if (ovl_data[8*k +: 4] != 4'h0) video = ovl_data[8*k +: 8];
                if (!hvpix) video = border_in;
                if (!hires) m_vout = video;
                else if (m_phase) m_vout = {m_temp, video[3:0]};
                m_temp  = video[3:0];
                m_phase = !m_phase;
            end
            accept = data_wr && (mq.size() < FDEPTH || popd);
            if (popd) void'(mq.pop_front());
            if (accept) mq.push_back(data_in);
        end
        @(posedge clk);
        #1;
        check("model_vplex_out", 32'(vplex_out), 32'(m_vout));
        check("model_underrun", 32'(underrun), 32'(m_und));
        check("model_data_rdy", 32'(data_rdy), 32'(mq.size() < FDEPTH));
    endtask

    task automatic idle();
        res = 0; line_start = 0; data_wr = 0; c1 = 0;
    endtask

    task automatic new_line(input logic [1:0] mode, input bit wr, input logic [31:0] w);
        idle();
        line_start = 1; render_mode = mode; data_wr = wr; data_in = w;
        tick();
        idle();
    endtask

    task automatic pixel();
        c1 = 1;
        tick();
        c1 = 0;
    endtask

    initial begin
        logic [7:0] exp;
        res = 1; c1 = 0; line_start = 0; data_wr = 0; data_in = '0;
        hvpix = 0; nogfx = 0; flash = 0; hires = 0; palsel = 4'h0;
        render_mode = 2'd0; border_in = 8'h05; ovl_data = '0;
        tick();
        tick();
        idle();
        check("rst_vplex_out", 32'(vplex_out), 32'h00);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_data_rdy", 32'(data_rdy), 32'h1);

        // ZX: gfx 0x8001 / attr 0x4738
        hvpix = 1;
        new_line(2'd0, 1, 32'h4738_8001);
        for (int i = 0; i < 16; i++) begin
            pixel();
            exp = (i < 7) ? 8'h07 : (i == 7) ? 8'h00 : (i == 8) ? 8'h0F : 8'h08;
            check("zx_pixel", 32'(vplex_out), 32'(exp));
        end

        // underrun: FIFO drained, border shown, index held
        pixel();
        check("underrun_border", 32'(vplex_out), 32'h05);
        check("underrun_set", 32'(underrun), 32'h1);
        pixel();
        data_wr = 1; data_in = 32'h4738_8001;
        tick();
        idle();
        pixel();
        check("underrun_resume_px0", 32'(vplex_out), 32'h07);
        check("underrun_sticky", 32'(underrun), 32'h1);
        new_line(2'd0, 0, '0);
        check("underrun_cleared", 32'(underrun), 32'h0);

        // 16c and 256c on the same word
        palsel = 4'hA;
        new_line(2'd1, 1, 32'h8765_4321);
        for (int i = 0; i < 8; i++) begin
            pixel();
            check("c16_pixel", 32'(vplex_out), 32'(c16_exp[i]));
        end
        new_line(2'd2, 1, 32'h8765_4321);
        for (int i = 0; i < 4; i++) begin
            pixel();
            check("c256_pixel", 32'(vplex_out), 32'(c256_exp[i]));
        end

        // overlay priority, then hi-res packing
        new_line(2'd2, 1, 32'h0C03_3333);
        ovl_data = {8'h2C, 8'h10};
        pixel();
        check("ovl_layer1", 32'(vplex_out), 32'h2C);
        ovl_data = {8'h00, 8'h10};
        pixel();
        check("ovl_bitmap", 32'(vplex_out), 32'h33);
        ovl_data = '0;
        hires = 1;
        pixel();
        check("hires_hold", 32'(vplex_out), 32'h33);
        pixel();
        check("hires_pair", 32'(vplex_out), 32'h3C);
        hires = 0;

        // FIFO fill, dropped write, write+pop while full, readback order
        new_line(2'd2, 0, '0);
        for (int k = 0; k < FDEPTH; k++) begin
            data_wr = 1; data_in = mkw(k);
            tick();
        end
        check("fifo_full_rdy", 32'(data_rdy), 32'h0);
        data_in = mkw(4);
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            pixel();
            check("fifo_w0", 32'(vplex_out), 32'(j));
        end
        c1 = 1; data_wr = 1; data_in = mkw(5);
        tick();
        idle();
        check("fifo_w0_last", 32'(vplex_out), 32'h03);
        check("fifo_wr_pop_full", 32'(data_rdy), 32'h0);
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                pixel();
                check("fifo_readback", 32'(vplex_out), 32'(16*rb_words[w] + j));
            end
        end
        check("fifo_drained_rdy", 32'(data_rdy), 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            res        = ($urandom_range(0, 599) == 0);
            line_start = !res && ($urandom_range(0, 39) == 0);
            c1         = !line_start && ($urandom_range(0, 9) < 6);
            data_wr    = ($urandom_range(0, 9) < 3);
            data_in    = $urandom;
            if (line_start) hires = 1'($urandom_range(0, 1));
            hvpix       = ($urandom_range(0, 9) != 0);
            nogfx       = ($urandom_range(0, 19) == 0);
            flash       = 1'($urandom_range(0, 1));
            palsel      = 4'($urandom);
            render_mode = 2'($urandom);
            border_in   = 8'($urandom);
            for (int k = 0; k < NLAYERS; k++)
                ovl_data[8*k +: 8] = ($urandom_range(0, 99) < 15) ? 8'($urandom) : 8'h00;
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
